// File: rtl/axi_tdd_pkg.sv
// Shared TDD types: frame FSM state and per-channel output mode.
package axi_tdd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;

  typedef enum logic {
    CH_LEVEL = 1'b0,
    CH_PULSE = 1'b1
  } ch_mode_t;

endpackage

// File: rtl/axi_tdd_channel_core.sv
// One TDD output channel: window compare, enable tracking and output stage.
module axi_tdd_channel_core
  import axi_tdd_pkg::*;
#(
  parameter int   NUM_WIN        = 2,
  parameter int   REGISTER_WIDTH = 32,
  parameter logic DEFAULT_POL    = 1'b0
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [REGISTER_WIDTH-1:0]         i_tdd_counter,
  input  state_t                            i_tdd_cstate,
  input  logic                              i_tdd_endof_frame,
  input  logic                              i_ch_en_next,
  input  logic                              i_pol,
  input  ch_mode_t                          i_mode,
  input  logic [NUM_WIN-1:0]                i_win_en,
  input  logic [NUM_WIN*REGISTER_WIDTH-1:0] i_t_on,
  input  logic [NUM_WIN*REGISTER_WIDTH-1:0] i_t_off,
  output logic                              o_out
);

  logic [NUM_WIN-1:0] w_hit_on;
  logic [NUM_WIN-1:0] w_hit_off;
  logic               w_running;

  logic r_set;
  logic r_rst;
  logic r_ch_en;
  logic r_out;

  assign w_running = (i_tdd_cstate == RUNNING);

  for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
    assign w_hit_on[w]  = i_win_en[w] &&
                          (i_tdd_counter == i_t_on[w*REGISTER_WIDTH +: REGISTER_WIDTH]);
    assign w_hit_off[w] = i_win_en[w] &&
                          (i_tdd_counter == i_t_off[w*REGISTER_WIDTH +: REGISTER_WIDTH]);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_set   <= 1'b0;
      r_rst   <= 1'b0;
      r_ch_en <= 1'b0;
      r_out   <= DEFAULT_POL;
    end else begin
      r_set <= w_running && (|w_hit_on);
      r_rst <= (w_running && (|w_hit_off)) || i_tdd_endof_frame;

      if (i_tdd_cstate == IDLE)
        r_ch_en <= 1'b0;
      else if ((i_tdd_cstate == ARMED) || i_tdd_endof_frame)
        r_ch_en <= i_ch_en_next;

      // rst wins over set so coincident on/off or eof on a t_on match stays inactive
      if (!r_ch_en || r_rst)
        r_out <= i_pol;
      else if (r_set)
        r_out <= ~i_pol;
      else if (i_mode == CH_PULSE)
        r_out <= i_pol;
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/axi_tdd_channel_bank.sv
// Bank of TDD output channels with double-buffered config applied at frame boundaries.
module axi_tdd_channel_bank
  import axi_tdd_pkg::*;
#(
  parameter int                NUM_CH           = 4,
  parameter int                NUM_WIN          = 2,
  parameter int                REGISTER_WIDTH   = 32,
  parameter logic [NUM_CH-1:0] DEFAULT_POLARITY = '0
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic [REGISTER_WIDTH-1:0]                i_tdd_counter,
  input  state_t                                   i_tdd_cstate,
  input  logic                                     i_tdd_endof_frame,
  input  logic [NUM_CH-1:0]                        i_asy_ch_en,
  input  logic [NUM_CH-1:0]                        i_asy_ch_pol,
  input  logic [NUM_CH-1:0]                        i_asy_ch_mode,
  input  logic [NUM_CH*NUM_WIN-1:0]                i_asy_win_en,
  input  logic [NUM_CH*NUM_WIN*REGISTER_WIDTH-1:0] i_asy_t_on,
  input  logic [NUM_CH*NUM_WIN*REGISTER_WIDTH-1:0] i_asy_t_off,
  input  logic                                     i_cfg_update,
  output logic                                     o_cfg_pending,
  output logic                                     o_cfg_applied,
  output logic [NUM_CH-1:0]                        o_out
);

  localparam int NW  = NUM_CH * NUM_WIN;
  localparam int WTH = NUM_WIN * REGISTER_WIDTH;

  logic [NUM_CH-1:0]            r_ch_en;
  logic [NUM_CH-1:0]            r_ch_pol;
  logic [NUM_CH-1:0]            r_ch_mode;
  logic [NW-1:0]                r_win_en;
  logic [NW*REGISTER_WIDTH-1:0] r_t_on;
  logic [NW*REGISTER_WIDTH-1:0] r_t_off;
  logic                         r_cfg_pending;
  logic                         r_cfg_applied;

  logic              w_running;
  logic              w_apply;
  logic              w_load;
  logic [NUM_CH-1:0] w_ch_en_next;
  logic [NUM_CH-1:0] w_out;

  assign w_running = (i_tdd_cstate == RUNNING);
  assign w_apply   = r_cfg_pending && (!w_running || i_tdd_endof_frame);
  // Outside RUNNING the shadow simply tracks the async inputs
  assign w_load    = !w_running || w_apply;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ch_en       <= '0;
      r_ch_pol      <= DEFAULT_POLARITY;
      r_ch_mode     <= '0;
      r_win_en      <= '0;
      r_t_on        <= '0;
      r_t_off       <= '0;
      r_cfg_pending <= 1'b0;
      r_cfg_applied <= 1'b0;
    end else begin
      if (w_load) begin
        r_ch_en   <= i_asy_ch_en;
        r_ch_pol  <= i_asy_ch_pol;
        r_ch_mode <= i_asy_ch_mode;
        r_win_en  <= i_asy_win_en;
        r_t_on    <= i_asy_t_on;
        r_t_off   <= i_asy_t_off;
      end
      r_cfg_applied <= w_apply;
      // a request landing on the applying cycle is kept for the next frame
      r_cfg_pending <= i_cfg_update || (r_cfg_pending && !w_apply);
    end
  end

  assign w_ch_en_next = w_load ? i_asy_ch_en : r_ch_en;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    axi_tdd_channel_core #(
      .NUM_WIN       (NUM_WIN),
      .REGISTER_WIDTH(REGISTER_WIDTH),
      .DEFAULT_POL   (DEFAULT_POLARITY[c])
    ) u_core (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_tdd_counter    (i_tdd_counter),
      .i_tdd_cstate     (i_tdd_cstate),
      .i_tdd_endof_frame(i_tdd_endof_frame),
      .i_ch_en_next     (w_ch_en_next[c]),
      .i_pol            (r_ch_pol[c]),
      .i_mode           (ch_mode_t'(r_ch_mode[c])),
      .i_win_en         (r_win_en[c*NUM_WIN +: NUM_WIN]),
      .i_t_on           (r_t_on[c*WTH +: WTH]),
      .i_t_off          (r_t_off[c*WTH +: WTH]),
      .o_out            (w_out[c])
    );
  end

  assign o_cfg_pending = r_cfg_pending;
  assign o_cfg_applied = r_cfg_applied;
  assign o_out         = w_out;

endmodule

// File: tb/tb_axi_tdd_channel_bank.sv
// Directed bench for axi_tdd_channel_bank with a spec-derived output model and scoreboard queue.
module tb_axi_tdd_channel_bank;
  import axi_tdd_pkg::*;

  localparam int                NUM_CH  = 4;
  localparam int                NUM_WIN = 2;
  localparam int                RW      = 32;
  localparam int                NW      = NUM_CH * NUM_WIN;
  localparam int                FRAME   = 50;
  localparam logic [NUM_CH-1:0] DEF     = 4'b0100;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [RW-1:0]        counter;
  state_t               cstate;
  logic                 eof;
  logic [NUM_CH-1:0]    a_en, a_pol, a_mode;
  logic [NW-1:0]        a_wen;
  logic [NW*RW-1:0]     a_on, a_off;
  logic                 cfg_update;
  logic                 cfg_pending, cfg_applied;
  logic [NUM_CH-1:0]    out;

  // model copies of the active configuration and channel state
  logic [NUM_CH-1:0]    m_en, m_pol, m_mode, m_en_r, m_out;
  logic [NW-1:0]        m_wen;
  logic [NW*RW-1:0]     m_on, m_off;
  logic [NUM_CH-1:0]    sb_q[$];

  int total = 0;
  int bad   = 0;

  axi_tdd_channel_bank #(
    .NUM_CH(NUM_CH), .NUM_WIN(NUM_WIN), .REGISTER_WIDTH(RW), .DEFAULT_POLARITY(DEF)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_tdd_counter(counter), .i_tdd_cstate(cstate),
    .i_tdd_endof_frame(eof), .i_asy_ch_en(a_en), .i_asy_ch_pol(a_pol),
    .i_asy_ch_mode(a_mode), .i_asy_win_en(a_wen), .i_asy_t_on(a_on),
    .i_asy_t_off(a_off), .i_cfg_update(cfg_update), .o_cfg_pending(cfg_pending),
    .o_cfg_applied(cfg_applied), .o_out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_win(input int c, input int w, input int on, input int off, input bit en);
    int idx;
    idx = c * NUM_WIN + w;
    a_wen[idx]          = en;
    a_on[idx*RW +: RW]  = 32'(on);
    a_off[idx*RW +: RW] = 32'(off);
  endtask

  task automatic sync_cfg();
    m_en = a_en; m_pol = a_pol; m_mode = a_mode;
    m_wen = a_wen; m_on = a_on; m_off = a_off;
  endtask

  // expected out two edges after these inputs are driven
  task automatic model(input state_t st, input int cnt, input bit e, input bit apply);
    logic [NUM_CH-1:0] s, r;
    int idx;
    if (st != RUNNING) sync_cfg();
    for (int c = 0; c < NUM_CH; c++) begin
      s[c] = 1'b0;
      r[c] = e;
      if (st == RUNNING)
        for (int w = 0; w < NUM_WIN; w++) begin
          idx = c * NUM_WIN + w;
          if (m_wen[idx]) begin
            if (m_on[idx*RW +: RW] == 32'(cnt))  s[c] = 1'b1;
            if (m_off[idx*RW +: RW] == 32'(cnt)) r[c] = 1'b1;
          end
        end
    end
    if (apply) sync_cfg();
    for (int c = 0; c < NUM_CH; c++) begin
      if (st == IDLE)                 m_en_r[c] = 1'b0;
      else if (st == ARMED || e)      m_en_r[c] = m_en[c];
      if (!m_en_r[c] || r[c])         m_out[c] = m_pol[c];
      else if (s[c])                  m_out[c] = ~m_pol[c];
      else if (m_mode[c])             m_out[c] = m_pol[c];
    end
    sb_q.push_back(m_out);
  endtask

  task automatic step(input state_t st, input int cnt, input bit e, input bit upd, input bit apply);
    logic [NUM_CH-1:0] exp_v;
    cstate = st; counter = 32'(cnt); eof = e; cfg_update = upd;
    model(st, cnt, e, apply);
    @(negedge clk);
    if (sb_q.size() > 2) begin
      exp_v = sb_q.pop_front();
      chk($sformatf("out st=%0d cnt=%0d", st, cnt), 32'(out), 32'(exp_v));
    end
    @(posedge clk);
    #1;
    eof = 1'b0; cfg_update = 1'b0;
  endtask

  task automatic arm();
    for (int i = 0; i < 3; i++) step(IDLE, 0, 0, 0, 0);
    step(ARMED, 0, 0, 0, 0);
    step(WAITING, 0, 0, 0, 0);
    step(WAITING, 0, 0, 0, 0);
  endtask

  task automatic run_frame();
    for (int k = 0; k < FRAME; k++) step(RUNNING, k, k == FRAME - 1, 0, 0);
  endtask

  initial begin
    rst = 1'b1; counter = '0; cstate = IDLE; eof = 1'b0; cfg_update = 1'b0;
    a_en = 4'b1111; a_pol = 4'b0100; a_mode = 4'b0100;
    a_wen = '0; a_on = '0; a_off = '0;
    set_win(0, 0, 10, 20, 1); set_win(0, 1, 25, 27, 0);
    set_win(1, 0, 5, 8, 1);   set_win(1, 1, 15, 18, 1);
    set_win(2, 0, 7, 100, 1); set_win(2, 1, 3, 100, 0);
    set_win(3, 0, 30, 30, 1); set_win(3, 1, FRAME - 1, 100, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", 32'(out), 32'(DEF));
    chk("reset pending", 32'(cfg_pending), 32'd0);
    chk("reset applied", 32'(cfg_applied), 32'd0);
    rst = 1'b0;
    m_out = DEF; m_en_r = '0;
    sync_cfg();

    // base config: level, two windows, pulse, coincident on/off and eof-on-t_on
    arm();
    run_frame();
    run_frame();

    // second window of ch1 disabled; update requested while idle applies next cycle
    a_wen[1*NUM_WIN + 1] = 1'b0;
    step(IDLE, 0, 0, 1, 0);
    chk("idle pending set", 32'(cfg_pending), 32'd1);
    chk("idle applied low", 32'(cfg_applied), 32'd0);
    step(IDLE, 0, 0, 0, 0);
    chk("idle pending clr", 32'(cfg_pending), 32'd0);
    chk("idle applied pulse", 32'(cfg_applied), 32'd1);
    step(IDLE, 0, 0, 0, 0);
    chk("idle applied end", 32'(cfg_applied), 32'd0);
    arm();
    run_frame();

    // mid-frame update of ch0 t_on 10->40 waits for end of frame
    for (int k = 0; k < FRAME; k++) begin
      if (k == 20) set_win(0, 0, 40, 20, 1);
      step(RUNNING, k, k == FRAME - 1, k == 20, k == FRAME - 1);
      if (k == 20) chk("run pending set", 32'(cfg_pending), 32'd1);
      if (k == 30) chk("run no applied", 32'(cfg_applied), 32'd0);
    end
    chk("eof applied pulse", 32'(cfg_applied), 32'd1);
    chk("eof pending clr", 32'(cfg_pending), 32'd0);
    step(RUNNING, 0, 0, 0, 0);
    chk("applied one cycle", 32'(cfg_applied), 32'd0);
    for (int k = 1; k < FRAME; k++) step(RUNNING, k, k == FRAME - 1, 0, 0);

    // reset while ch0 is high with a request pending
    set_win(0, 0, 10, 20, 1);
    arm();
    for (int k = 0; k < 15; k++) begin
      step(RUNNING, k, 0, k == 13, 0);
      if (k == 13) chk("pre-reset pending", 32'(cfg_pending), 32'd1);
    end
    chk("pre-reset out0 high", 32'(out[0]), 32'd1);
    rst = 1'b1; counter = 32'd15; cstate = RUNNING;
    @(posedge clk);
    #1;
    chk("mid reset out", 32'(out), 32'(DEF));
    chk("mid reset pending", 32'(cfg_pending), 32'd0);
    chk("mid reset applied", 32'(cfg_applied), 32'd0);
    rst = 1'b0;
    sb_q.delete();
    m_out = DEF; m_en_r = '0;
    for (int i = 0; i < 4; i++) step(IDLE, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
